// File: rtl/fifo_word_packer.sv
// Byte-FIFO consumer: packs BYTES_PER_WORD bytes little-endian into one word and
// presents it on valid/ready. A flush or an idle timeout emits a partial word.
module fifo_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_fifo_empty,
  input  logic [7:0]                        in_fifo_data,
  output logic                              out_fifo_read,
  output logic [8*BYTES_PER_WORD-1:0]       out_word_data,
  output logic [$clog2(BYTES_PER_WORD):0]   out_word_bytes,
  output logic                              out_word_valid,
  input  logic                              in_word_ready,
  input  logic                              in_flush
);

  localparam int CW = $clog2(BYTES_PER_WORD) + 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL     = CW'(BYTES_PER_WORD);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    HOLD
  } state_t;

  state_t                          state, state_nx;
  logic [CW-1:0]                   req_cnt, cap_cnt;
  logic [CW-1:0]                   bytes_q, bytes_nx;
  logic                            rd_pend;
  logic [IW-1:0]                   idle_cnt;
  logic [BYTES_PER_WORD-1:0][7:0]  lanes;

  logic word_done, timeout, accept, idle_tick, have_bytes;

  // A pop issued now lands in a lane on the following edge (rd_pend).
  assign word_done  = rd_pend && ((cap_cnt + CW'(1)) == FULL);
  assign timeout    = (idle_cnt == IDLE_MAX);
  assign accept     = (state == HOLD) && in_word_ready;
  assign have_bytes = (cap_cnt != '0) || rd_pend;
  assign idle_tick  = (state == COLLECT) && (cap_cnt != '0) && !rd_pend && in_fifo_empty;

  always_comb begin
    out_fifo_read = !rst && (state == COLLECT) && !in_fifo_empty && (req_cnt < FULL);
  end

  assign out_word_valid = (state == HOLD);
  assign out_word_data  = lanes;
  assign out_word_bytes = bytes_q;

  always_comb begin
    state_nx = state;
    bytes_nx = bytes_q;
    case (state)
      COLLECT: begin
        // A completing capture wins over a simultaneous flush/timeout.
        if (word_done) begin
          state_nx = HOLD;
          bytes_nx = FULL;
        end else if ((in_flush || timeout) && have_bytes && (req_cnt < FULL)) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (!rd_pend) begin
          state_nx = HOLD;
          bytes_nx = cap_cnt;
        end
      end
      HOLD: begin
        if (in_word_ready) begin
          state_nx = COLLECT;
          bytes_nx = '0;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COLLECT;
      req_cnt  <= '0;
      cap_cnt  <= '0;
      rd_pend  <= 1'b0;
      idle_cnt <= '0;
      lanes    <= '0;
      bytes_q  <= '0;
    end else begin
      state   <= state_nx;
      bytes_q <= bytes_nx;
      rd_pend <= out_fifo_read;
      if (accept) begin
        req_cnt  <= '0;
        cap_cnt  <= '0;
        lanes    <= '0;
        idle_cnt <= '0;
      end else begin
        if (out_fifo_read) req_cnt <= req_cnt + CW'(1);
        if (rd_pend) begin
          for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
            if (cap_cnt == CW'(k)) lanes[k] <= in_fifo_data;
          end
          cap_cnt <= cap_cnt + CW'(1);
        end
        if ((state != COLLECT) || out_fifo_read) idle_cnt <= '0;
        else if (idle_tick && !timeout)          idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

endmodule
